// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave cooking timer: state encoding and BCD constants.
package microwave_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TENS_RELOAD = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_down_counter3.sv
// Three-digit M:ST:SO time register with shift-in entry, clear and BCD decrement with borrow.
module bcd_down_counter3
  import microwave_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [BCD_W-1:0] shift_digit,
  input  logic             dec,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             is_zero,
  output logic             will_be_zero
);

  // Clear beats entry beats decrement; 0:00 is left alone so the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else if (clear) begin
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else if (shift_en) begin
      min_ones <= sec_tens;
      sec_tens <= sec_ones;
      sec_ones <= shift_digit;
    end else if (dec) begin
      if (sec_ones != '0) begin
        sec_ones <= sec_ones - 1'b1;
      end else if (sec_tens != '0) begin
        sec_tens <= sec_tens - 1'b1;
        sec_ones <= BCD_MAX;
      end else if (min_ones != '0) begin
        min_ones <= min_ones - 1'b1;
        sec_tens <= SEC_TENS_RELOAD;
        sec_ones <= BCD_MAX;
      end
    end
  end

  assign is_zero      = (min_ones == '0) && (sec_tens == '0) && (sec_ones == '0);
  assign will_be_zero = (min_ones == '0) && (sec_tens == '0) && (sec_ones == BCD_W'(1));

endmodule

// File: rtl/microwave_timer_seq.sv
// Cooking-timer sequencer: key/tick edge detection, IDLE/RUN/PAUSE/DONE control and done hold.
module microwave_timer_seq
  import microwave_pkg::*;
#(
  parameter int DONE_CYCLES = 200,
  parameter int DONE_W      = 8
) (
  input  logic             clk_100Hz,
  input  logic             resetn,
  input  logic [BCD_W-1:0] bcd,
  input  logic             loadn,
  input  logic             pgt_1Hz,
  input  logic             startn,
  input  logic             stopn,
  input  logic             door_closed,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             mag_on,
  output logic             done,
  output logic [1:0]       state
);

  state_t            cur_state, nxt_state;
  logic              loadn_q, startn_q, stopn_q, pgt_q;
  logic              load_ev, start_ev, stop_ev, tick_ev;
  logic              clear, shift_en, dec;
  logic              is_zero, will_be_zero;
  logic [DONE_W-1:0] hold_cnt;

  // History regs idle at the inactive level so releasing reset never looks like a key press.
  always_ff @(posedge clk_100Hz or negedge resetn) begin
    if (!resetn) begin
      loadn_q  <= 1'b1;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
      pgt_q    <= 1'b0;
    end else begin
      loadn_q  <= loadn;
      startn_q <= startn;
      stopn_q  <= stopn;
      pgt_q    <= pgt_1Hz;
    end
  end

  assign load_ev  = loadn_q & ~loadn;
  assign start_ev = startn_q & ~startn;
  assign stop_ev  = stopn_q & ~stopn;
  assign tick_ev  = ~pgt_q & pgt_1Hz;

  always_ff @(posedge clk_100Hz or negedge resetn) begin
    if (!resetn) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_ff @(posedge clk_100Hz or negedge resetn) begin
    if (!resetn) begin
      hold_cnt <= '0;
    end else if (cur_state != ST_DONE) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Within a cycle: stop, then door open, then tick, then start.
  always_comb begin
    nxt_state = cur_state;
    clear     = 1'b0;
    shift_en  = 1'b0;
    dec       = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        if (stop_ev) begin
          clear = 1'b1;
        end else if (start_ev && door_closed && !is_zero) begin
          nxt_state = ST_RUN;
        end else if (load_ev && (bcd <= BCD_MAX)) begin
          shift_en = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop_ev || !door_closed) begin
          nxt_state = ST_PAUSE;
        end else if (tick_ev) begin
          dec = 1'b1;
          if (will_be_zero) begin
            nxt_state = ST_DONE;
          end
        end
      end
      ST_PAUSE: begin
        if (stop_ev) begin
          clear     = 1'b1;
          nxt_state = ST_IDLE;
        end else if (start_ev && door_closed) begin
          nxt_state = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop_ev || (hold_cnt == DONE_W'(DONE_CYCLES - 1))) begin
          nxt_state = ST_IDLE;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  bcd_down_counter3 u_time (
    .clk          (clk_100Hz),
    .rst_n        (resetn),
    .clear        (clear),
    .shift_en     (shift_en),
    .shift_digit  (bcd),
    .dec          (dec),
    .min_ones     (min_ones),
    .sec_tens     (sec_tens),
    .sec_ones     (sec_ones),
    .is_zero      (is_zero),
    .will_be_zero (will_be_zero)
  );

  assign mag_on = (cur_state == ST_RUN);
  assign done   = (cur_state == ST_DONE);
  assign state  = cur_state;

endmodule

// File: tb/tb_microwave_timer_seq.sv
// Scoreboard bench for microwave_timer_seq: each driven cycle queues the expected time/state.
module tb_microwave_timer_seq;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int K_NONE      = 0;
  localparam int K_LOAD      = 1;
  localparam int K_START     = 2;
  localparam int K_STOP      = 3;
  localparam int K_TICK      = 4;
  localparam int K_STOP_TICK = 5;

  logic       clk_100Hz = 1'b0;
  logic       resetn;
  logic [3:0] bcd;
  logic       loadn, pgt_1Hz, startn, stopn, door_closed;
  logic [3:0] min_ones, sec_tens, sec_ones;
  logic       mag_on, done;
  logic [1:0] state;

  int assert_count = 0;
  int fail_count   = 0;

  string       sb_tag[$];
  logic [13:0] sb_exp[$];

  always #5 clk_100Hz = ~clk_100Hz;

  microwave_timer_seq dut (
    .clk_100Hz   (clk_100Hz),
    .resetn      (resetn),
    .bcd         (bcd),
    .loadn       (loadn),
    .pgt_1Hz     (pgt_1Hz),
    .startn      (startn),
    .stopn       (stopn),
    .door_closed (door_closed),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .mag_on      (mag_on),
    .done        (done),
    .state       (state)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic popCompare();
    string       tag;
    logic [13:0] e;
    tag = sb_tag.pop_front();
    e   = sb_exp.pop_front();
    checkOutput({tag, "_time"},  {20'd0, min_ones, sec_tens, sec_ones}, {20'd0, e[11:0]});
    checkOutput({tag, "_state"}, {30'd0, state}, {30'd0, e[13:12]});
    checkOutput({tag, "_mag"},   {31'd0, mag_on}, {31'd0, (e[13:12] == S_RUN)});
    checkOutput({tag, "_done"},  {31'd0, done},   {31'd0, (e[13:12] == S_DONE)});
  endtask

  task automatic cycleExpect(input string tag, input logic [11:0] t, input logic [1:0] s);
    sb_tag.push_back(tag);
    sb_exp.push_back({s, t});
    @(posedge clk_100Hz);
    #1;
    popCompare();
  endtask

  // One active cycle of the chosen key/tick, then one release cycle; time/state hold across both.
  task automatic applyStimulus(input string tag, input int kind, input logic [3:0] b,
                               input logic dr, input logic [11:0] t, input logic [1:0] s);
    door_closed = dr;
    bcd         = b;
    loadn       = !(kind == K_LOAD);
    startn      = !(kind == K_START);
    stopn       = !(kind == K_STOP || kind == K_STOP_TICK);
    pgt_1Hz     = (kind == K_TICK || kind == K_STOP_TICK);
    cycleExpect({tag, "_act"}, t, s);
    loadn   = 1'b1;
    startn  = 1'b1;
    stopn   = 1'b1;
    pgt_1Hz = 1'b0;
    cycleExpect({tag, "_rel"}, t, s);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_time"},  {20'd0, min_ones, sec_tens, sec_ones}, 32'h0);
    checkOutput({tag, "_state"}, {30'd0, state}, {30'd0, S_IDLE});
    checkOutput({tag, "_mag"},   {31'd0, mag_on}, 32'd0);
    checkOutput({tag, "_done"},  {31'd0, done}, 32'd0);
  endtask

  initial begin
    resetn      = 1'b0;
    bcd         = 4'd0;
    loadn       = 1'b1;
    pgt_1Hz     = 1'b0;
    startn      = 1'b1;
    stopn       = 1'b1;
    door_closed = 1'b1;
    #2;
    checkReset("reset_init");
    @(negedge clk_100Hz);
    resetn = 1'b1;
    applyStimulus("post_reset", K_NONE, 4'd0, 1'b1, 12'h000, S_IDLE);

    // Digit entry, invalid key and overflow of the fourth digit
    applyStimulus("key1",  K_LOAD, 4'd1,  1'b1, 12'h001, S_IDLE);
    applyStimulus("key2",  K_LOAD, 4'd2,  1'b1, 12'h012, S_IDLE);
    applyStimulus("key3",  K_LOAD, 4'd3,  1'b1, 12'h123, S_IDLE);
    applyStimulus("key15", K_LOAD, 4'd15, 1'b1, 12'h123, S_IDLE);
    applyStimulus("key4",  K_LOAD, 4'd4,  1'b1, 12'h234, S_IDLE);
    applyStimulus("idle_clear", K_STOP, 4'd0, 1'b1, 12'h000, S_IDLE);

    // 0:02 countdown into DONE and the 200-cycle hold
    applyStimulus("key2b",  K_LOAD,  4'd2, 1'b1, 12'h002, S_IDLE);
    applyStimulus("start2", K_START, 4'd0, 1'b1, 12'h002, S_RUN);
    applyStimulus("tick1",  K_TICK,  4'd0, 1'b1, 12'h001, S_RUN);
    applyStimulus("tick0",  K_TICK,  4'd0, 1'b1, 12'h000, S_DONE);
    applyStimulus("done_load",  K_LOAD,  4'd7, 1'b1, 12'h000, S_DONE);
    applyStimulus("done_start", K_START, 4'd0, 1'b1, 12'h000, S_DONE);
    for (int i = 0; i < 194; i++) cycleExpect("done_hold", 12'h000, S_DONE);
    cycleExpect("done_exit", 12'h000, S_IDLE);

    // Minute borrow, door-open pause and resume
    applyStimulus("key1m",  K_LOAD,  4'd1, 1'b1, 12'h001, S_IDLE);
    applyStimulus("key0a",  K_LOAD,  4'd0, 1'b1, 12'h010, S_IDLE);
    applyStimulus("key0b",  K_LOAD,  4'd0, 1'b1, 12'h100, S_IDLE);
    applyStimulus("start100", K_START, 4'd0, 1'b1, 12'h100, S_RUN);
    applyStimulus("borrow", K_TICK,  4'd0, 1'b1, 12'h059, S_RUN);
    applyStimulus("door_open", K_NONE, 4'd0, 1'b0, 12'h059, S_PAUSE);
    applyStimulus("pause_tick", K_TICK, 4'd0, 1'b0, 12'h059, S_PAUSE);
    applyStimulus("open_start", K_START, 4'd0, 1'b0, 12'h059, S_PAUSE);
    applyStimulus("resume", K_START, 4'd0, 1'b1, 12'h059, S_RUN);

    // Stop beats tick in RUN; second stop clears
    applyStimulus("stop_a", K_STOP, 4'd0, 1'b1, 12'h059, S_PAUSE);
    applyStimulus("stop_b", K_STOP, 4'd0, 1'b1, 12'h000, S_IDLE);
    applyStimulus("key1t",  K_LOAD, 4'd1, 1'b1, 12'h001, S_IDLE);
    applyStimulus("key0t",  K_LOAD, 4'd0, 1'b1, 12'h010, S_IDLE);
    applyStimulus("start10", K_START, 4'd0, 1'b1, 12'h010, S_RUN);
    applyStimulus("stop_tick", K_STOP_TICK, 4'd0, 1'b1, 12'h010, S_PAUSE);
    applyStimulus("stop_clr", K_STOP, 4'd0, 1'b1, 12'h000, S_IDLE);

    // Ignored starts and loadn during RUN
    applyStimulus("start_zero", K_START, 4'd0, 1'b1, 12'h000, S_IDLE);
    applyStimulus("key5",       K_LOAD,  4'd5, 1'b1, 12'h005, S_IDLE);
    applyStimulus("start_open", K_START, 4'd0, 1'b0, 12'h005, S_IDLE);
    applyStimulus("start5",     K_START, 4'd0, 1'b1, 12'h005, S_RUN);
    applyStimulus("run_load",   K_LOAD,  4'd8, 1'b1, 12'h005, S_RUN);
    applyStimulus("tick4",      K_TICK,  4'd0, 1'b1, 12'h004, S_RUN);

    // Tens-of-seconds above 5 counts as entered
    applyStimulus("stop_c", K_STOP, 4'd0, 1'b1, 12'h004, S_PAUSE);
    applyStimulus("stop_d", K_STOP, 4'd0, 1'b1, 12'h000, S_IDLE);
    applyStimulus("key7", K_LOAD, 4'd7, 1'b1, 12'h007, S_IDLE);
    applyStimulus("key5b", K_LOAD, 4'd5, 1'b1, 12'h075, S_IDLE);
    applyStimulus("start75", K_START, 4'd0, 1'b1, 12'h075, S_RUN);
    applyStimulus("tick74", K_TICK, 4'd0, 1'b1, 12'h074, S_RUN);

    // Asynchronous reset in the middle of a 1:23 cook
    applyStimulus("stop_e", K_STOP, 4'd0, 1'b1, 12'h074, S_PAUSE);
    applyStimulus("stop_f", K_STOP, 4'd0, 1'b1, 12'h000, S_IDLE);
    applyStimulus("rk1", K_LOAD, 4'd1, 1'b1, 12'h001, S_IDLE);
    applyStimulus("rk2", K_LOAD, 4'd2, 1'b1, 12'h012, S_IDLE);
    applyStimulus("rk3", K_LOAD, 4'd3, 1'b1, 12'h123, S_IDLE);
    applyStimulus("start123", K_START, 4'd0, 1'b1, 12'h123, S_RUN);
    @(posedge clk_100Hz);
    #3;
    resetn = 1'b0;
    #1;
    checkReset("reset_midrun");
    @(negedge clk_100Hz);
    resetn = 1'b1;
    applyStimulus("after_reset", K_NONE, 4'd0, 1'b1, 12'h000, S_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/microwave_timer_seq.md
Name: microwave_timer_seq

Overview:
Sequencer for the microwave cooking timer. Consumes the digit stream from timer_controler (bcd, loadn) and the 1 Hz tick (pgt_1Hz). Holds the entered time as three BCD digits (M:ST:SO) and runs a start/pause/stop/done state machine that counts the time down and gates the magnetron. Sits between the keypad encoder/timer controller and the display/magnetron drivers, all in the clk_100Hz domain.

Parameters:
DONE_CYCLES, 200, clk_100Hz cycles that done stays high after countdown ends (2 s).
DONE_W, 8, width of the done-hold counter; must hold DONE_CYCLES.

Ports:
clk_100Hz  input  1  system clock, 100 Hz; all state on rising edge.
resetn  input  1  asynchronous active-low reset.
bcd  input  4  digit from timer_controler; valid 0..9, 10..15 ignored.
loadn  input  1  active-low digit strobe; a digit is taken on its 1->0 transition.
pgt_1Hz  input  1  1 Hz tick; one decrement per 0->1 transition.
startn  input  1  active-low start key; acts on its 1->0 transition.
stopn  input  1  active-low stop/clear key; acts on its 1->0 transition.
door_closed  input  1  1 = door closed.
min_ones  output  4  minutes digit M.
sec_tens  output  4  seconds tens digit ST.
sec_ones  output  4  seconds ones digit SO.
mag_on  output  1  magnetron enable; high only in RUN.
done  output  1  end-of-cook indicator; high only in DONE.
state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (async, resetn=0): all digits 0, state IDLE, mag_on 0, done 0. Edge-detect history regs reset to 1 for loadn, startn and stopn, and to 0 for pgt_1Hz. No spurious edge after release.
- Edge detect: each event fires for one cycle when the current sample differs from the previous registered sample in the active direction. The action takes effect on that same clock edge, so outputs change one cycle after the input transition is sampled.
- Digit entry, IDLE only: a loadn event with bcd<=9 shifts left. min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=bcd. The old min_ones is discarded. A loadn event with bcd>9, or in any other state, is ignored.
- No validation of ST>5. 0:75 counts 75 s.
- Decrement (BCD, 3 digits): if SO>0, SO-1. Else if ST>0, ST-1 and SO=9. Else if M>0, M-1, ST=5 and SO=9. 0:00 never decrements, so there is no wrap.
- IDLE: start event with door_closed=1 and time!=0:00 -> RUN. A start with time 0:00 or the door open is ignored. A stop event clears all digits to 0.
- RUN: mag_on=1. A pgt_1Hz event decrements the time. If the result is 0:00, go to DONE on the same edge.
  - Stop event -> PAUSE; time is held.
  - door_closed=0 (level) -> PAUSE; time is held.
- PAUSE: mag_on=0, time held.
  - Start event with door_closed=1 -> RUN.
  - Stop event -> IDLE with digits cleared.
  - pgt_1Hz is ignored.
- DONE: done=1, digits 0:00. The hold counter loads 0 on entry and increments each cycle. At DONE_CYCLES-1 -> IDLE. A stop event -> IDLE immediately. Start and loadn are ignored.
- Priority within one cycle: stop > door open > pgt_1Hz decrement > start.
  - A stop plus a pgt_1Hz event in RUN: go to PAUSE, no decrement.
  - A door open plus a start in PAUSE: stay in PAUSE.
- Outputs are registered or decoded from state only, with no combinational path from inputs.

Decomposition:
- Shared package microwave_pkg: state encoding (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE), BCD_W=4, BCD_MAX=9, SEC_TENS_RELOAD=5.
- One sub-module, bcd_down_counter3. It holds M/ST/SO with shift-load, synchronous clear and decrement-with-borrow, and outputs a zero flag plus a will-be-zero flag. It uses the same clock and reset.
- The FSM, edge detectors and done-hold counter stay in microwave_timer_seq.

Test Plan:
- Reset mid-RUN at 1:23: resetn low -> digits 0:00, IDLE, mag_on 0 immediately, before any clock edge.
- Keys 1,2,3 via loadn pulses, then bcd=15 pulse: display 1:23 after the three digits, unchanged by the invalid key. A fourth digit 4 gives 2:34.
- At 0:02, start with door closed -> RUN, mag_on 1. Two pgt_1Hz pulses -> 0:01 then 0:00 with DONE on the same edge. done high for exactly 200 cycles, then IDLE.
- At 1:00 in RUN, one pgt_1Hz pulse -> 0:59. Open door -> PAUSE, mag_on 0, pgt ignored. Close door and start -> RUN resumes from 0:59.
- In RUN at 0:10, stop and pgt_1Hz on the same cycle -> PAUSE at 0:10. A second stop -> IDLE at 0:00.
- Start at 0:00, or start with the door open at 0:05 -> stays IDLE. Loadn during RUN -> digits unchanged.
